// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display scanner: active-high segment table and polarity helper.
package hex_display_pkg;

    localparam logic [6:0] SEG_OFF_H = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns for nibbles 0..F
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
        logic [6:0] result;
        if (active_low) begin
            result = ~pattern;
        end else begin
            result = pattern;
        end
        return result;
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Display scanner signal bundle: value/load side from the datapath, segment/digit side to the pins.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic                      blank_lz;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     dig_en;
    logic                      frame_start;

    modport master (output load, value, blank_lz, input seg, dig_en, frame_start);
    modport slave  (input load, value, blank_lz, output seg, dig_en, frame_start);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-7-segment decoder with blanking and selectable output polarity.
module hex_to_seg7
    import hex_display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);
    localparam logic POL_LOW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Table lookup, forced off when blanked
    always_comb begin
        if (blank) begin
            seg = seg_polarity(SEG_OFF_H, POL_LOW);
        end else begin
            seg = seg_polarity(SEG_HEX[nibble], POL_LOW);
        end
    end
endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex 7-segment driver: prescaled digit scan, frame-synchronous value update,
// leading-zero blanking, registered segment and digit-enable outputs.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    hex_display_scanner_if.slave  bus
);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL_LOW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PW-1:0]         prescale_r;
    logic [IW-1:0]         index_r;
    logic [VW-1:0]         pending_r;
    logic [VW-1:0]         display_r;
    logic [6:0]            seg_r;
    logic [NUM_DIGITS-1:0] dig_en_r;
    logic                  frame_start_r;

    logic                  tick_s;
    logic                  last_s;
    logic                  boundary_s;
    logic [NUM_DIGITS-1:0] zero_above_s;
    logic [NUM_DIGITS-1:0] onehot_s;
    logic [3:0]            nibble_s;
    logic                  blank_s;
    logic [6:0]            seg_s;

    assign tick_s     = (prescale_r == PW'(PRESCALE - 1));
    assign last_s     = (index_r == IW'(NUM_DIGITS - 1));
    assign boundary_s = tick_s && last_s;

    // zero_above_s[i]: display digits NUM_DIGITS-1 down to i are all zero
    always_comb begin
        zero_above_s = {NUM_DIGITS{1'b0}};
        zero_above_s[NUM_DIGITS-1] = (display_r[VW-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_above_s[i] = zero_above_s[i+1] && (display_r[4*i +: 4] == 4'h0);
        end
    end

    // Current digit select, its nibble and blank decision
    always_comb begin
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (index_r == IW'(i));
        end
        nibble_s = display_r[{index_r, 2'b00} +: 4];
        if (bus.blank_lz && (index_r != {IW{1'b0}})) begin
            blank_s = zero_above_s[index_r];
        end else begin
            blank_s = 1'b0;
        end
    end

    hex_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .nibble (nibble_s),
        .blank  (blank_s),
        .seg    (seg_s)
    );

    // Scan state, value registers and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_r    <= {PW{1'b0}};
            index_r       <= {IW{1'b0}};
            pending_r     <= {VW{1'b0}};
            display_r     <= {VW{1'b0}};
            seg_r         <= seg_polarity(SEG_OFF_H, POL_LOW);
            dig_en_r      <= DIG_OFF;
            frame_start_r <= 1'b0;
        end else begin
            if (tick_s) begin
                prescale_r <= {PW{1'b0}};
                index_r    <= last_s ? {IW{1'b0}} : index_r + IW'(1);
            end else begin
                prescale_r <= prescale_r + PW'(1);
            end
            if (bus.load) begin
                pending_r <= bus.value;
            end
            // A load on the boundary cycle goes straight to the display
            if (boundary_s) begin
                display_r <= bus.load ? bus.value : pending_r;
            end
            frame_start_r <= boundary_s;
            seg_r         <= seg_s;
            dig_en_r      <= POL_LOW ? ~onehot_s : onehot_s;
        end
    end

    assign bus.seg         = seg_r;
    assign bus.dig_en      = dig_en_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized self-checking bench: a 4-digit/prescale-3/active-low scanner and a 1-digit/
// prescale-1/active-high scanner checked every cycle against a cycle-count based reference.
module tb_hex_display_scanner;
    localparam int ND = 4;
    localparam int PS = 3;
    localparam int FR = ND * PS;
    localparam logic [6:0] SEG_REF [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hex_display_scanner_if #(.NUM_DIGITS(ND)) ifa ();
    hex_display_scanner_if #(.NUM_DIGITS(1))  ifb ();

    hex_display_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .ACTIVE_LOW(1)) dut_a (
        .clock (clock), .reset (reset), .bus (ifa.slave));
    hex_display_scanner #(.NUM_DIGITS(1), .PRESCALE(1), .ACTIVE_LOW(0)) dut_b (
        .clock (clock), .reset (reset), .bus (ifb.slave));

    int n_vec = 0;
    int n_err = 0;
    int k = 0;                  // edges since reset release
    logic [15:0] ma_disp, ma_pend;
    logic [3:0]  mb_disp, mb_pend;
    logic [11:0] exp_a;         // {seg, dig_en, frame_start}
    logic [8:0]  exp_b;

    // Advance one clock; expected outputs follow from the edge count and the frame rules
    task automatic cycle();
        int idx;
        bit bnd;
        logic [3:0] nib;
        logic [6:0] pat;
        logic [3:0] onehot;
        if (reset) begin
            exp_a = {7'h7F, 4'hF, 1'b0};
            exp_b = {7'h00, 1'b0, 1'b0};
            k = 0;
            ma_disp = 16'h0; ma_pend = 16'h0;
            mb_disp = 4'h0;  mb_pend = 4'h0;
        end else begin
            idx = (k / PS) % ND;
            bnd = (k % FR) == FR - 1;
            nib = 4'((ma_disp >> (4 * idx)) & 16'hF);
            if (ifa.blank_lz && idx > 0 && (ma_disp >> (4 * idx)) == 16'h0) pat = 7'h00;
            else pat = SEG_REF[nib];
            onehot = 4'b0001 << idx;
            exp_a = {~pat, ~onehot, bnd};
            if (bnd) ma_disp = ifa.load ? ifa.value : ma_pend;
            if (ifa.load) ma_pend = ifa.value;
            exp_b = {SEG_REF[mb_disp], 1'b1, 1'b1};
            mb_disp = ifb.load ? ifb.value : mb_pend;
            if (ifb.load) mb_pend = ifb.value;
            k++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifa.load = 1'b0; ifa.value = 16'h0; ifa.blank_lz = 1'b0;
        ifb.load = 1'b0; ifb.value = 4'h0;  ifb.blank_lz = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle();
            n_vec++;
            if ({ifa.seg, ifa.dig_en, ifa.frame_start} !== exp_a) begin
                n_err++; $display("FAIL reset_a: got %h expected %h", {ifa.seg, ifa.dig_en, ifa.frame_start}, exp_a);
            end
            n_vec++;
            if ({ifb.seg, ifb.dig_en, ifb.frame_start} !== exp_b) begin
                n_err++; $display("FAIL reset_b: got %h expected %h", {ifb.seg, ifb.dig_en, ifb.frame_start}, exp_b);
            end
        end
        reset = 1'b0;
        cycle();
        n_vec++;
        if (ifa.dig_en !== 4'hE || ifa.seg !== ~7'h3F) begin
            n_err++; $display("FAIL first_after_reset: got dig_en=%h seg=%h expected dig_en=e seg=%h", ifa.dig_en, ifa.seg, ~7'h3F);
        end
    endtask

    // Runs n cycles with current inputs, comparing both scanners each cycle
    task automatic test_run(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            cycle();
            ifa.load = 1'b0;
            ifb.load = 1'b0;
            n_vec++;
            if ({ifa.seg, ifa.dig_en, ifa.frame_start} !== exp_a) begin
                n_err++; $display("FAIL %s_a k=%0d: got %h expected %h", name, k, {ifa.seg, ifa.dig_en, ifa.frame_start}, exp_a);
            end
            n_vec++;
            if ({ifb.seg, ifb.dig_en, ifb.frame_start} !== exp_b) begin
                n_err++; $display("FAIL %s_b k=%0d: got %h expected %h", name, k, {ifb.seg, ifb.dig_en, ifb.frame_start}, exp_b);
            end
        end
    endtask

    task automatic test_load_1234();
        ifa.load = 1'b1; ifa.value = 16'h1234;
        ifb.load = 1'b1; ifb.value = 4'hF;
        test_run("load_1234", 2 * FR + 2);
    endtask

    task automatic test_blank();
        ifa.blank_lz = 1'b1;
        ifa.load = 1'b1; ifa.value = 16'h0050;
        test_run("blank_0050", 2 * FR + 1);
        ifa.load = 1'b1; ifa.value = 16'h0000;
        test_run("blank_0000", 2 * FR);
        ifa.blank_lz = 1'b0;
        test_run("unblank", FR);
    endtask

    task automatic test_back_to_back();
        int fs_count;
        while ((k % FR) != 0) test_run("align", 1);
        ifa.load = 1'b1; ifa.value = 16'hAAAA;
        test_run("multi_a", 2);
        ifa.load = 1'b1; ifa.value = 16'hBBBB;
        test_run("multi_b", 1);
        while ((k % FR) != FR - 1) test_run("multi_wait", 1);
        ifa.load = 1'b1; ifa.value = 16'hCCCC;
        fs_count = 0;
        for (int c = 0; c < FR; c++) begin
            test_run("multi_c", 1);
            if (ifa.frame_start === 1'b1) fs_count++;
        end
        n_vec++;
        if (fs_count != 1) begin
            n_err++; $display("FAIL frame_start_pulse: got %0d pulses expected 1", fs_count);
        end
        n_vec++;
        if (ma_disp !== 16'hCCCC) begin
            n_err++; $display("FAIL boundary_load_model: got %h expected cccc", ma_disp);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        for (int v = 0; v < 4; v++) begin
            ifa.load = 1'b1; ifa.value = vals[v];
            ifb.load = 1'b1; ifb.value = 4'(v * 5);
            test_run("sweep", 2 * FR);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ifa.load = ($urandom_range(0, 7) == 0);
            ifa.value = 16'($urandom);
            ifa.blank_lz = 1'($urandom);
            ifb.load = 1'($urandom);
            ifb.value = 4'($urandom);
            test_run("random", 1);
        end
        ifa.blank_lz = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        while ((k % FR) != 1) test_run("align2", 1);
        ifa.load = 1'b1; ifa.value = 16'h9999;
        test_run("pre_reset", 3);
        reset = 1'b1;
        cycle();
        n_vec++;
        if ({ifa.seg, ifa.dig_en, ifa.frame_start} !== exp_a) begin
            n_err++; $display("FAIL mid_reset: got %h expected %h", {ifa.seg, ifa.dig_en, ifa.frame_start}, exp_a);
        end
        reset = 1'b0;
        test_run("post_reset", 2 * FR);
        n_vec++;
        if (ifa.dig_en === 4'hE && ifa.seg !== ~7'h3F) begin
            n_err++; $display("FAIL pending_discarded: got seg=%h expected %h", ifa.seg, ~7'h3F);
        end
    endtask

    initial begin
        test_reset();
        test_load_1234();
        test_blank();
        test_back_to_back();
        test_sweep();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
